store_data_queue: RTL and testbench

- Parametrised store-data path between register file/ACC/PC and data memory.
- Selects one of N_SRC 16-bit sources on a store, tags it with address and source index, and queues it in a DEPTH-entry FIFO.
- Drives data memory through a valid/ready handshake.
- Replaces the purely combinational store mux; adds registered output, back-pressure and select-error reporting.

---
 rtl/store_dq_pkg.sv | 22 ++
 rtl/sel_prio_enc.sv | 23 ++
 rtl/store_data_queue.sv | 129 ++++++++++++
 tb/tb_store_data_queue.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_dq_pkg.sv
// Shared types and constants for the store-data queue.
// Source indices, default widths and the queue entry layout.
package store_dq_pkg;

    localparam int SRC_X   = 0;
    localparam int SRC_Y   = 1;
    localparam int SRC_ACC = 2;
    localparam int SRC_PC  = 3;

    localparam int DEF_DW    = 16;
    localparam int DEF_AW    = 16;
    localparam int DEF_NSRC  = 4;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_SW    = $clog2(DEF_NSRC);

    typedef struct packed {
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] data;
        logic [DEF_SW-1:0] src;
    } sdq_entry_t;

endpackage

// File: rtl/sel_prio_enc.sv
// Priority encoder: lowest set bit wins.
// Also flags any-set and more-than-one-set.
module sel_prio_enc #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          any,
    output logic          multi
);

    // Scan from the top so the lowest set index is written last.
    always_comb begin
        idx   = '0;
        any   = |vec;
        multi = |(vec & (vec - N'(1)));
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/store_data_queue.sv
// Store-data path: source select, tag and FIFO toward data memory.
// Define STORE_SEL_CHECK_EN to add the sticky multi-hot select flag sel_err.
module store_data_queue
    import store_dq_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int AW    = DEF_AW,
    parameter int N_SRC = DEF_NSRC,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SW    = $clog2(N_SRC),
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_SRC*DW-1:0] src_data,
    input  logic [N_SRC-1:0]    src_sel,
    input  logic                store,
    input  logic [AW-1:0]       store_addr,
    output logic                store_ready,
    output logic                dm_valid,
    input  logic                dm_ready,
    output logic [AW-1:0]       dm_addr,
    output logic [DW-1:0]       dm_data,
    output logic [SW-1:0]       dm_src,
    output logic [CW-1:0]       count,
    output logic                drop_err,
    input  logic                clr_err
`ifdef STORE_SEL_CHECK_EN
    ,
    output logic                sel_err
`endif
);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] src;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sel_idx;
    logic          sel_any;
    logic [DW-1:0] sel_data;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;

`ifdef STORE_SEL_CHECK_EN
    logic          sel_multi;
`else
    logic          sel_multi_unused;
`endif

    sel_prio_enc #(
        .N  (N_SRC),
        .IW (SW)
    ) u_enc (
        .vec   (src_sel),
        .idx   (sel_idx),
        .any   (sel_any),
`ifdef STORE_SEL_CHECK_EN
        .multi (sel_multi)
`else
        .multi (sel_multi_unused)
`endif
    );

    // Pick the winning source word out of the packed bus.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (sel_idx == SW'(i)) sel_data = src_data[i*DW +: DW];
        end
    end

    assign full        = (cnt == CW'(DEPTH));
    assign empty       = (cnt == '0);
    assign push        = store && sel_any && !full;
    assign pop         = !empty && dm_ready;
    assign drop        = store && sel_any && full;
    assign store_ready = !full;
    assign dm_valid    = !empty;
    assign count       = cnt;
    assign dm_addr     = mem[rptr].addr;
    assign dm_data     = mem[rptr].data;
    assign dm_src      = mem[rptr].src;

    // FIFO storage, pointers, occupancy and sticky drop flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            drop_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= '{addr: store_addr,
                               data: sel_data,
                               src:  sel_idx};
                wptr      <= wptr + PW'(1);
            end
            if (pop) rptr <= rptr + PW'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (drop)         drop_err <= 1'b1;
            else if (clr_err) drop_err <= 1'b0;
        end
    end

`ifdef STORE_SEL_CHECK_EN
    // Sticky flag for stores issued with a multi-hot select.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  sel_err <= 1'b0;
        else if (store && sel_multi) sel_err <= 1'b1;
        else if (clr_err)            sel_err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_store_data_queue.sv
// Self-checking bench for store_data_queue.
// Reference model: a plain queue of tagged entries.
module tb_store_data_queue;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int NS = 4;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NS*DW-1:0] src_data = '0;
    logic [NS-1:0] src_sel = '0;
    logic          store = 1'b0;
    logic [AW-1:0] store_addr = '0;
    logic          store_ready;
    logic          dm_valid;
    logic          dm_ready = 1'b0;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_data;
    logic [1:0]    dm_src;
    logic [2:0]    count;
    logic          drop_err;
    logic          clr_err = 1'b0;
`ifdef STORE_SEL_CHECK_EN
    logic          sel_err;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            s;
    } ent_t;

    ent_t q[$];
    bit   m_drop = 0;
    bit   m_sel = 0;

    store_data_queue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_data    (src_data),
        .src_sel     (src_sel),
        .store       (store),
        .store_addr  (store_addr),
        .store_ready (store_ready),
        .dm_valid    (dm_valid),
        .dm_ready    (dm_ready),
        .dm_addr     (dm_addr),
        .dm_data     (dm_data),
        .dm_src      (dm_src),
        .count       (count),
        .drop_err    (drop_err),
        .clr_err     (clr_err)
`ifdef STORE_SEL_CHECK_EN
        ,
        .sel_err     (sel_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic int winner(logic [NS-1:0] s);
        for (int i = 0; i < NS; i++) if (s[i]) return i;
        return -1;
    endfunction

    // Advance one clock, updating the model from the inputs at the edge.
    task automatic tick();
        int   w;
        bit   full;
        bit   do_push;
        bit   do_pop;
        ent_t e;
        w       = winner(src_sel);
        full    = (q.size() == D);
        do_pop  = (q.size() > 0) && dm_ready;
        do_push = store && (w >= 0) && !full;
        if (w >= 0) begin
            e.a = store_addr;
            e.d = src_data[w*DW +: DW];
            e.s = w;
        end
        if (store && w >= 0 && full) m_drop = 1;
        else if (clr_err) m_drop = 0;
        if (store && $countones(src_sel) > 1) m_sel = 1;
        else if (clr_err) m_sel = 0;
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
        #1;
    endtask

    task automatic idle();
        store   = 0;
        clr_err = 0;
        src_sel = '0;
    endtask

    task automatic drain();
        int budget;
        idle();
        dm_ready = 1;
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            tick();
            budget++;
        end
        checks++;
        if (dm_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty dm_valid=%0b want 0", dm_valid);
        end
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dm_valid !== 1'b0 || count !== 3'd0 || store_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state valid=%0b count=%0d ready=%0b want 0/0/1",
                     dm_valid, count, store_ready);
        end
        checks++;
        if (drop_err !== 1'b0 || dm_data !== 16'h0 || dm_addr !== 16'h0 ||
            dm_src !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs drop=%0b data=%h addr=%h src=%0d want zeros",
                     drop_err, dm_data, dm_addr, dm_src);
        end
        rst_n = 1;
        q.delete();
        m_drop = 0;
        m_sel = 0;
        tick();
    endtask

    task automatic test_single_store();
        src_data = {16'h0, 16'hBEEF, 16'h0, 16'h0};
        src_sel = 4'b0100;
        store_addr = 16'h0010;
        dm_ready = 1;
        store = 1;
        checks++;
        if (dm_valid !== 1'b0) begin
            failures++;
            $display("FAIL no_bypass dm_valid=%0b want 0", dm_valid);
        end
        tick();
        idle();
        checks++;
        if (dm_valid !== 1'b1 || dm_data !== 16'hBEEF || dm_addr !== 16'h0010 ||
            dm_src !== 2'd2) begin
            failures++;
            $display("FAIL single_head valid=%0b data=%h addr=%h src=%0d want 1/beef/0010/2",
                     dm_valid, dm_data, dm_addr, dm_src);
        end
        tick();
        checks++;
        if (count !== 3'd0 || dm_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_pop count=%0d valid=%0b want 0/0", count, dm_valid);
        end
    endtask

    task automatic test_fill_drop_drain();
        int k;
        int budget;
        logic [DW-1:0] held;
        dm_ready = 0;
        for (int i = 0; i < 4; i++) begin
            src_data = {$urandom, $urandom};
            src_data[i*DW +: DW] = DW'(i + 1);
            src_sel = 4'(1 << i);
            store_addr = AW'(16'h100 + i);
            store = 1;
            tick();
        end
        idle();
        checks++;
        if (count !== 3'd4 || store_ready !== 1'b0 || drop_err !== 1'b0) begin
            failures++;
            $display("FAIL fill count=%0d ready=%0b drop=%0b want 4/0/0",
                     count, store_ready, drop_err);
        end
        src_sel = 4'b0001;
        src_data = 64'h9999_9999_9999_9999;
        store = 1;
        dm_ready = 1;
        tick();
        idle();
        dm_ready = 0;
        checks++;
        if (drop_err !== 1'b1 || count !== 3'd3 || dm_data !== 16'd2) begin
            failures++;
            $display("FAIL drop_full drop=%0b count=%0d data=%h want 1/3/0002",
                     drop_err, count, dm_data);
        end
        clr_err = 1;
        tick();
        clr_err = 0;
        checks++;
        if (drop_err !== 1'b0) begin
            failures++;
            $display("FAIL clr_drop drop=%0b want 0", drop_err);
        end
        k = 2;
        budget = 0;
        while (k <= 4 && budget < 60) begin
            checks++;
            if (dm_valid !== 1'b1 || dm_data !== DW'(k) || dm_src !== 2'(k - 1) ||
                dm_addr !== AW'(16'h100 + k - 1)) begin
                failures++;
                $display("FAIL drain_order data=%h src=%0d addr=%h want %h/%0d/%h",
                         dm_data, dm_src, dm_addr, DW'(k), k - 1, 16'h100 + k - 1);
            end
            held = dm_data;
            dm_ready = 1'($urandom_range(0, 1));
            tick();
            if (dm_ready) k++;
            else begin
                checks++;
                if (dm_data !== held) begin
                    failures++;
                    $display("FAIL stall_stable data=%h want %h", dm_data, held);
                end
            end
            budget++;
        end
        checks++;
        if (k != 5 || count !== 3'd0) begin
            failures++;
            $display("FAIL drain_done k=%0d count=%0d want 5/0", k, count);
        end
        dm_ready = 0;
    endtask

    task automatic test_multi_hot();
        dm_ready = 0;
        src_data = {16'h2222, 16'h7777, 16'h1111, 16'h5555};
        src_sel = 4'b1010;
        store_addr = 16'h0042;
        store = 1;
        tick();
        idle();
        checks++;
        if (dm_data !== 16'h1111 || dm_src !== 2'd1 || dm_addr !== 16'h0042) begin
            failures++;
            $display("FAIL multi_hot data=%h src=%0d addr=%h want 1111/1/0042",
                     dm_data, dm_src, dm_addr);
        end
`ifdef STORE_SEL_CHECK_EN
        checks++;
        if (sel_err !== 1'b1) begin
            failures++;
            $display("FAIL sel_err_set sel_err=%0b want 1", sel_err);
        end
        clr_err = 1;
        tick();
        clr_err = 0;
        checks++;
        if (sel_err !== 1'b0) begin
            failures++;
            $display("FAIL sel_err_clr sel_err=%0b want 0", sel_err);
        end
`endif
        drain();
    endtask

    task automatic test_zero_sel();
        dm_ready = 0;
        src_sel = 4'b0000;
        src_data = {$urandom, $urandom};
        store = 1;
        tick();
        idle();
        checks++;
        if (count !== 3'd0 || dm_valid !== 1'b0 || drop_err !== 1'b0) begin
            failures++;
            $display("FAIL zero_sel count=%0d valid=%0b drop=%0b want 0/0/0",
                     count, dm_valid, drop_err);
        end
    endtask

    task automatic test_back_to_back();
        dm_ready = 0;
        for (int i = 0; i < 2; i++) begin
            src_sel = 4'b0001;
            src_data = {48'h0, 16'(16'hA000 + i)};
            store_addr = 16'(i);
            store = 1;
            tick();
        end
        dm_ready = 1;
        for (int i = 0; i < 10; i++) begin
            src_sel = 4'(1 << (i % 4));
            src_data = {$urandom, $urandom};
            store_addr = 16'($urandom);
            store = 1;
            checks++;
            if (dm_valid !== 1'b1 || dm_data !== q[0].d || dm_addr !== q[0].a) begin
                failures++;
                $display("FAIL b2b_head data=%h addr=%h want %h/%h",
                         dm_data, dm_addr, q[0].d, q[0].a);
            end
            tick();
            checks++;
            if (count !== 3'd2) begin
                failures++;
                $display("FAIL b2b_count count=%0d want 2", count);
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        dm_ready = 0;
        for (int i = 0; i < 3; i++) begin
            src_sel = 4'b0010;
            src_data = {$urandom, $urandom};
            store = 1;
            tick();
        end
        src_sel = 4'b0001;
        store = 1;
        tick();
        tick();
        idle();
        checks++;
        if (count !== 3'd4 || drop_err !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset count=%0d drop=%0b want 4/1", count, drop_err);
        end
        dm_ready = 1;
        tick();
        dm_ready = 0;
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (dm_valid !== 1'b0 || count !== 3'd0 || drop_err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset valid=%0b count=%0d drop=%0b want 0/0/0",
                     dm_valid, count, drop_err);
        end
        q.delete();
        m_drop = 0;
        m_sel = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            store = 1'($urandom_range(0, 1));
            src_sel = 4'($urandom);
            src_data = {$urandom, $urandom};
            store_addr = 16'($urandom);
            dm_ready = ($urandom_range(0, 3) != 0);
            clr_err = ($urandom_range(0, 9) == 0);
            checks++;
            if (dm_valid !== (q.size() > 0) || count !== 3'(q.size()) ||
                store_ready !== (q.size() < D) || drop_err !== m_drop) begin
                failures++;
                $display("FAIL rand_state valid=%0b count=%0d ready=%0b drop=%0b want %0b/%0d/%0b/%0b",
                         dm_valid, count, store_ready, drop_err,
                         q.size() > 0, q.size(), q.size() < D, m_drop);
            end
            if (q.size() > 0) begin
                checks++;
                if (dm_data !== q[0].d || dm_addr !== q[0].a || dm_src !== 2'(q[0].s)) begin
                    failures++;
                    $display("FAIL rand_head data=%h addr=%h src=%0d want %h/%h/%0d",
                             dm_data, dm_addr, dm_src, q[0].d, q[0].a, q[0].s);
                end
            end
`ifdef STORE_SEL_CHECK_EN
            checks++;
            if (sel_err !== m_sel) begin
                failures++;
                $display("FAIL rand_sel_err sel_err=%0b want %0b", sel_err, m_sel);
            end
`endif
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_fill_drop_drain();
        test_multi_hot();
        test_zero_sel();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
